crc_finalize: RTL and testbench
===============================

CRC_FINALIZE -- requirements
Module: crc_finalize

Interface
REQ-001 SHALL have parameter CRC_W, default 32, CRC width in bits, multiple of 8, range 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the sideband channel tag.
REQ-003 SHALL have parameter XOR_OUT, default all-ones of CRC_W, final XOR constant.
REQ-004 SHALL have parameter RST_MODE, default 2'b01, active mode after reset.
REQ-005 SHALL have port clk  input  1  clock; rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have cfg_load  input  1  one-cycle request to load cfg_mode/cfg_xor_en.
REQ-007 SHALL have cfg_mode  input  2  00 pass, 01 per-byte bit reflect, 10 full-word bit reflect, 11 byte swap.
REQ-008 SHALL have cfg_xor_en  input  1  apply XOR_OUT after the mode transform.
REQ-009 SHALL have cfg_pending  output  1  load requested but not yet applied.
REQ-010 SHALL have s_valid  input  1; s_ready  output  1; s_crc  input  CRC_W; s_tag  input  TAG_W.
REQ-011 SHALL have m_valid  output  1; m_ready  input  1; m_crc  output  CRC_W; m_tag  output  TAG_W.
REQ-012 SHALL have frame_cnt  output  16  count of completed output handshakes.

Function
REQ-013 Input beat accepted when s_valid && s_ready; output beat completes when m_valid && m_ready.
REQ-014 Accepted beat SHALL be transformed with the active config and written into a 2-entry FIFO together with its tag.
REQ-015 Transform order SHALL be: mode transform first, then XOR with XOR_OUT if active xor_en = 1.
REQ-016 m_valid SHALL be FIFO-not-empty; m_crc/m_tag SHALL show the head entry; latency accept -> m_valid = 1 cycle.
REQ-017 s_ready SHALL be high when FIFO count < 2; sustained throughput 1 beat/cycle with m_ready high.
REQ-018 Count 1 with push and pop in the same cycle: count stays 1, order preserved; s_ready is low at count 2, so no push then.
REQ-019 m_crc/m_tag SHALL hold stable while m_valid && !m_ready.
REQ-020 cfg_load SHALL capture cfg_mode/cfg_xor_en into a shadow register and set cfg_pending.
REQ-021 Shadow SHALL be copied to active config in the first cycle with FIFO empty and no accept; cfg_pending clears that cycle.
REQ-022 While cfg_pending = 1, s_ready SHALL be held low, so the pipeline drains.
REQ-023 cfg_load while pending SHALL overwrite the shadow (last request wins).
REQ-024 cfg_load with FIFO already empty SHALL apply in the next cycle; the first beat after that uses the new config.
REQ-025 frame_cnt SHALL increment by 1 per output handshake and wrap 16'hFFFF -> 0.

Reset
REQ-026 On rst: FIFO empty, m_valid = 0, m_crc = 0, m_tag = 0, s_ready = 0 while rst high, then 1 from the first cycle after release.
REQ-027 On rst: active mode = RST_MODE, active xor_en = 1, shadow cleared, cfg_pending = 0, frame_cnt = 0.
REQ-028 Reset mid-operation SHALL discard all buffered beats and any pending load without producing output.

Structure
REQ-029 Mode encodings and transform functions (reflect8, reflect_word, byte_swap) SHALL live in the shared package crc_pkg.
REQ-030 The 2-entry FIFO SHALL be sub-module crc_fin_fifo, parametrised by data width CRC_W+TAG_W.

Verification
REQ-031 CRC_W=32, mode 01, xor 1, s_crc 0x12345678, tag 3 -> next cycle m_crc 0xB7D395E1, m_tag 3.
REQ-032 Mode 10, xor 0, 0x12345678 -> 0x1E6A2C48; mode 11, xor 0 -> 0x78563412; mode 00, xor 1 -> 0xEDCBA987.
REQ-033 Hold m_ready low, drive 3 beats back-to-back -> s_ready drops after 2 accepts, outputs stay stable; release -> all 3 emerge in order.
REQ-034 cfg_load mode 00 with 2 beats buffered -> s_ready low and cfg_pending 1 until the FIFO drains; the next beat passes unchanged.
REQ-035 Preload frame_cnt to 0xFFFF via 65535 handshakes, then 1 more -> frame_cnt 0; rst asserted with FIFO full -> m_valid 0 immediately, no stale output after release.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared mode encodings, config record and CRC output transforms for crc_finalize.
// Transforms work on a 64-bit container; the caller passes the live width.
package crc_pkg;

  localparam int unsigned CrcMaxW = 64;

  typedef enum logic [1:0] {
    ModePass        = 2'b00,
    ModeReflect8    = 2'b01,
    ModeReflectWord = 2'b10,
    ModeByteSwap    = 2'b11
  } crc_mode_e;

  typedef struct packed {
    crc_mode_e mode;
    logic      xor_en;
  } crc_cfg_t;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CrcMaxW-1:0] reflect_bytes(input logic [CrcMaxW-1:0] d);
    logic [CrcMaxW-1:0] r;
    for (int unsigned b = 0; b < CrcMaxW / 8; b++) r[8*b +: 8] = reflect8(d[8*b +: 8]);
    return r;
  endfunction

  function automatic logic [CrcMaxW-1:0] reflect_word(input logic [CrcMaxW-1:0] d,
                                                      input int unsigned w);
    logic [CrcMaxW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CrcMaxW; i++) begin
      if (i < w) r[i] = d[w-1-i];
    end
    return r;
  endfunction

  function automatic logic [CrcMaxW-1:0] byte_swap(input logic [CrcMaxW-1:0] d,
                                                   input int unsigned w);
    logic [CrcMaxW-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < CrcMaxW / 8; b++) begin
      if (b < w / 8) r[8*b +: 8] = d[8*(w/8-1-b) +: 8];
    end
    return r;
  endfunction

  function automatic logic [CrcMaxW-1:0] crc_transform(input logic [CrcMaxW-1:0] d,
                                                       input int unsigned w,
                                                       input crc_mode_e mode);
    logic [CrcMaxW-1:0] r;
    unique case (mode)
      ModePass:        r = d;
      ModeReflect8:    r = reflect_bytes(d);
      ModeReflectWord: r = reflect_word(d, w);
      ModeByteSwap:    r = byte_swap(d, w);
      default:         r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/crc_fin_fifo.sv
// Two-entry FIFO with registered storage; head entry is always presented on rdata_o.
module crc_fin_fifo #(
  parameter int unsigned DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/crc_finalize.sv
// CRC finalisation stage: mode transform plus optional output XOR, buffered in a
// 2-entry FIFO, with a drain-then-apply configuration update path.
module crc_finalize
  import crc_pkg::*;
#(
  parameter int unsigned       CRC_W    = 32,
  parameter int unsigned       TAG_W    = 4,
  parameter logic [CRC_W-1:0]  XOR_OUT  = '1,
  parameter logic [1:0]        RST_MODE = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_xor_en,
  output logic             cfg_pending,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CRC_W-1:0] s_crc,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CRC_W-1:0] m_crc,
  output logic [TAG_W-1:0] m_tag,
  output logic [15:0]      frame_cnt
);

  crc_cfg_t           cfg_act_q, cfg_shd_q;
  logic               pending_q;
  logic [15:0]        frame_cnt_q;
  logic               fifo_empty, fifo_full;
  logic               accept, emit;
  logic [CrcMaxW-1:0] xformed;
  logic [CRC_W-1:0]   crc_out;
  logic               unused_xformed_hi;
  logic [CRC_W+TAG_W-1:0] fifo_rdata;

  // New beats are refused while a config change waits for the pipeline to drain.
  assign s_ready = !rst && !fifo_full && !pending_q;
  assign accept  = s_valid && s_ready;
  assign m_valid = !fifo_empty;
  assign emit    = m_valid && m_ready;

  always_comb begin
    xformed = crc_transform(CrcMaxW'(s_crc), CRC_W, cfg_act_q.mode);
    crc_out = xformed[CRC_W-1:0] ^ (cfg_act_q.xor_en ? XOR_OUT : '0);
    unused_xformed_hi = ^(xformed >> CRC_W);
  end

  crc_fin_fifo #(
    .DATA_W (CRC_W + TAG_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .wdata_i ({crc_out, s_tag}),
    .pop_i   (emit),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign m_crc = fifo_rdata[CRC_W+TAG_W-1:TAG_W];
  assign m_tag = fifo_rdata[TAG_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_act_q <= '{mode: crc_mode_e'(RST_MODE), xor_en: 1'b1};
      cfg_shd_q <= '0;
      pending_q <= 1'b0;
    end else if (cfg_load) begin
      cfg_shd_q <= '{mode: crc_mode_e'(cfg_mode), xor_en: cfg_xor_en};
      pending_q <= 1'b1;
    end else if (pending_q && fifo_empty && !accept) begin
      cfg_act_q <= cfg_shd_q;
      pending_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if (emit) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign cfg_pending = pending_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_crc_finalize.sv
// Scoreboard bench for crc_finalize: drivers queue hand-computed results, a negedge
// monitor pops and compares on each output handshake.
module tb_crc_finalize;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_load = 1'b0;
  logic [1:0]  cfg_mode = 2'b00;
  logic        cfg_xor_en = 1'b0;
  logic        cfg_pending;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_crc = '0;
  logic [3:0]  s_tag = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_crc;
  logic [3:0]  m_tag;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic [31:0] crc;
    logic [3:0]  tag;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] hs_cnt = 16'd0;

  always #5 clk = ~clk;

  crc_finalize dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_load    (cfg_load),
    .cfg_mode    (cfg_mode),
    .cfg_xor_en  (cfg_xor_en),
    .cfg_pending (cfg_pending),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_crc       (s_crc),
    .s_tag       (s_tag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_crc       (m_crc),
    .m_tag       (m_tag),
    .frame_cnt   (frame_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got crc %h tag %h expected none", m_crc, m_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_crc", 64'(m_crc), 64'(mon_e.crc));
        check("out_tag", 64'(m_tag), 64'(mon_e.tag));
      end
      hs_cnt = hs_cnt + 16'd1;
    end
  end

  task automatic send(input logic [31:0] crc, input logic [3:0] tag,
                      input logic [31:0] exp, input bit track);
    int n = 0;
    s_valid = 1'b1;
    s_crc   = crc;
    s_tag   = tag;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got s_ready 0 expected 1 within 50 cycles");
    end else if (track) begin
      exp_q.push_back('{crc: exp, tag: tag});
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((m_valid || cfg_pending) && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (m_valid || cfg_pending) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got m_valid %b pending %b expected 0 0", m_valid, cfg_pending);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] mode, input logic xe);
    cfg_load   = 1'b1;
    cfg_mode   = mode;
    cfg_xor_en = xe;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    drain();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_crc", 64'(m_crc), 64'd0);
    check("rst_m_tag", 64'(m_tag), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_pending", 64'(cfg_pending), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;

    // Reset config: per-byte reflect with XOR; output one cycle after accept.
    send(32'h12345678, 4'd3, 32'hB7D395E1, 1'b1);
    check("latency_m_valid", 64'(m_valid), 64'd1);
    check("latency_m_crc", 64'(m_crc), 64'hB7D395E1);
    drain();

    set_cfg(2'b10, 1'b0);
    send(32'h12345678, 4'd5, 32'h1E6A2C48, 1'b1);
    set_cfg(2'b11, 1'b0);
    send(32'h12345678, 4'd6, 32'h78563412, 1'b1);
    set_cfg(2'b00, 1'b1);
    send(32'h12345678, 4'd7, 32'hEDCBA987, 1'b1);
    set_cfg(2'b01, 1'b0);
    send(32'h0F00FF01, 4'd1, 32'hF000FF80, 1'b1);

    // Backpressure: two beats fill the FIFO, the third waits until the sink resumes.
    set_cfg(2'b11, 1'b0);
    m_ready = 1'b0;
    send(32'h12345678, 4'd1, 32'h78563412, 1'b1);
    send(32'hAABBCCDD, 4'd2, 32'hDDCCBBAA, 1'b1);
    @(negedge clk);
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_m_valid", 64'(m_valid), 64'd1);
    fork
      send(32'h01020304, 4'd3, 32'h04030201, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("hold_crc", 64'(m_crc), 64'h78563412);
          check("hold_tag", 64'(m_tag), 64'd1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Config load with two beats buffered holds off input until the FIFO drains.
    m_ready = 1'b0;
    send(32'h11223344, 4'd8, 32'h44332211, 1'b1);
    send(32'h55667788, 4'd9, 32'h88776655, 1'b1);
    cfg_load   = 1'b1;
    cfg_mode   = 2'b00;
    cfg_xor_en = 1'b0;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("pend_flag", 64'(cfg_pending), 64'd1);
      check("pend_s_ready", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    drain();
    check("pend_cleared", 64'(cfg_pending), 64'd0);
    send(32'hCAFEF00D, 4'd10, 32'hCAFEF00D, 1'b1);
    drain();

    // Walk frame_cnt up to 0xFFFF, then one more handshake wraps it.
    check("frame_cnt_mid", 64'(frame_cnt), 64'(hs_cnt));
    begin
      int n;
      n = 65535 - int'(hs_cnt);
      for (int i = 0; i < n; i++) begin
        logic [31:0] v;
        v = 32'(i);
        send(v, v[3:0], v, 1'b1);
      end
    end
    drain();
    check("frame_cnt_ffff", 64'(frame_cnt), 64'hFFFF);
    send(32'hDEADBEEF, 4'd4, 32'hDEADBEEF, 1'b1);
    drain();
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    // Reset with a full FIFO and a pending load: nothing may emerge afterwards.
    m_ready = 1'b0;
    send(32'hA5A5A5A5, 4'd1, 32'h0, 1'b0);
    send(32'h5A5A5A5A, 4'd2, 32'h0, 1'b0);
    cfg_load = 1'b1;
    cfg_mode = 2'b10;
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", 64'(m_valid), 64'd0);
    check("mid_rst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs_cnt = 16'd0;
    m_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_m_valid", 64'(m_valid), 64'd0);
    end
    check("mid_rst_pending", 64'(cfg_pending), 64'd0);
    check("mid_rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    send(32'h12345678, 4'd3, 32'hB7D395E1, 1'b1);
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
